// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: parametrised fetch PC with stall hold and latched redirect.
// Optional return address stack is built when PC_RAS_EN is defined.
module fetch_pc_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                OFF_W      = 16,
    parameter int                INSN_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call_en,
    input  logic              ret_en,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              redirect_pend,
    output logic              ras_underflow
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        {ADDR_W{1'b1}} << $clog2(INSN_BYTES);

    logic signed [OFF_W-1:0] off_s;
    logic [ADDR_W-1:0] seq_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] ret_tgt;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pend_addr;
    logic ret_ok;
    logic sel_ret;
    logic sel_jmp;
    logic sel_br;
    logic redir;

    assign off_s   = branch_off;
    assign seq_tgt = (pc_out + ADDR_W'(INSN_BYTES)) & ALIGN_MASK;
    assign br_tgt  = (pc_out + ADDR_W'(off_s)) & ALIGN_MASK;
    assign jmp_tgt = jump_target & ALIGN_MASK;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wp;
    logic [PTR_W-1:0]  ras_top;
    logic [PTR_W:0]    ras_cnt;
    logic              do_pop;
    logic              do_push;

    assign ras_top = ras_wp - PTR_W'(1);
    assign ret_ok  = ret_en & (ras_cnt != '0);
    assign ret_tgt = ras_mem[ras_top] & ALIGN_MASK;
    assign do_pop  = ret_ok & ~stall;
    assign do_push = call_en & jump_en & ~stall;

    // Stack pointer, occupancy and the registered underflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_wp        <= '0;
            ras_cnt       <= '0;
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= ret_en & (ras_cnt == '0);
            if (do_push && !do_pop) begin
                ras_wp <= ras_wp + PTR_W'(1);
                if (ras_cnt != FULL)
                    ras_cnt <= ras_cnt + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                ras_wp  <= ras_top;
                ras_cnt <= ras_cnt - (PTR_W+1)'(1);
            end
        end
    end

    // Return address storage; pop+push rewrites the top in place.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push && do_pop)
                ras_mem[ras_top] <= seq_tgt;
            else if (do_push)
                ras_mem[ras_wp] <= seq_tgt;
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_in;

    assign unused_ras_in = &{1'b0, call_en, ret_en};
    assign ret_ok        = 1'b0;
    assign ret_tgt       = '0;
    assign ras_underflow = 1'b0;
`endif

    // Priority select of the next target: ret > jump > branch > sequential.
    always_comb begin
        sel_ret = ret_ok;
        sel_jmp = jump_en & ~ret_ok;
        sel_br  = branch_en & ~jump_en & ~ret_ok;
        redir   = sel_ret | sel_jmp | sel_br;
        tgt     = seq_tgt;
        unique case (1'b1)
            sel_ret: tgt = ret_tgt;
            sel_jmp: tgt = jmp_tgt;
            sel_br:  tgt = br_tgt;
            default: tgt = seq_tgt;
        endcase
    end

    // PC, bubble flag and the redirect held across a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= RESET_ADDR;
            pc_valid      <= 1'b0;
            redirect_pend <= 1'b0;
            pend_addr     <= '0;
        end else if (stall) begin
            pc_valid <= 1'b1;
            if (redir) begin
                redirect_pend <= 1'b1;
                pend_addr     <= tgt;
            end
        end else begin
            redirect_pend <= 1'b0;
            if (redir) begin
                pc_out   <= tgt;
                pc_valid <= 1'b0;
            end else if (redirect_pend) begin
                pc_out   <= pend_addr;
                pc_valid <= 1'b0;
            end else begin
                pc_out   <= seq_tgt;
                pc_valid <= 1'b1;
            end
        end
    end

endmodule
